stack_unit: RTL

//  Hardware PUSH/POP engine for the MiniRISC CPU. Consumes the SP value exported by the register

---
 rtl/stack_unit.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/stack_unit.sv
// ---------------------------------------------------------------------------
// stack_unit
//   PUSH/POP engine for the MiniRISC CPU. It takes the SP value exported by
//   the register file, does the single data-memory access, then writes the
//   updated SP back through the register-file write port.
//
//   The stack is full-descending. SP == STACK_TOP means the stack is empty.
//   A push stores the byte at SP-1. A pop reads the byte at SP.
//
//   The control unit issues one-cycle requests and then waits for done.
//
// Ports
//   clk, rst        clock and asynchronous active-low reset
//   push_req        start a push of push_data (sampled only while idle)
//   pop_req         start a pop (sampled only while idle; push wins)
//   push_data       byte to push, latched with push_req
//   busy            operation in progress
//   done            one-cycle completion pulse (success or error)
//   pop_data        last successfully popped byte
//   ovf / unf       one-cycle error pulses, coincident with done
//   sp_in           current SP from the register file
//   rf_wr_en        SP write-back strobe
//   rf_addr         write-back address (constant SP_ADDR)
//   rf_wr_data      new SP value
//   mem_addr        data-memory address
//   mem_wr, mem_rd  data-memory strobes (mem_din is valid in the read cycle)
//   mem_dout        data-memory write data
//   mem_din         data-memory read data
// ---------------------------------------------------------------------------
module stack_unit #(
  parameter logic [3:0] SP_ADDR     = 4'd15,
  parameter logic [7:0] STACK_TOP   = 8'd127,
  parameter logic [7:0] STACK_LIMIT = 8'd64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_req,
  input  logic       pop_req,
  input  logic [7:0] push_data,
  output logic       busy,
  output logic       done,
  output logic [7:0] pop_data,
  output logic       ovf,
  output logic       unf,
  input  logic [7:0] sp_in,
  output logic       rf_wr_en,
  output logic [3:0] rf_addr,
  output logic [7:0] rf_wr_data,
  output logic [7:0] mem_addr,
  output logic       mem_wr,
  output logic       mem_rd,
  output logic [7:0] mem_dout,
  input  logic [7:0] mem_din
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PUSH_MEM = 2'd1,
    POP_MEM  = 2'd2,
    SP_WB    = 2'd3
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] sp_q, sp_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       ovf_q, ovf_d;
  logic       unf_q, unf_d;
  logic       rf_wr_en_q, rf_wr_en_d;
  logic       mem_wr_q, mem_wr_d;
  logic       mem_rd_q, mem_rd_d;
  logic [7:0] pop_data_q, pop_data_d;
  logic [7:0] mem_addr_q, mem_addr_d;
  logic [7:0] mem_dout_q, mem_dout_d;
  logic [7:0] rf_wr_data_q, rf_wr_data_d;

  // True when a push would go below the lowest legal SP.
  function automatic logic is_full(input logic [7:0] sp);
    return (sp == STACK_LIMIT);
  endfunction

  // True when the stack holds nothing to pop.
  function automatic logic is_empty(input logic [7:0] sp);
    return (sp == STACK_TOP);
  endfunction

  // Next-state and next-output logic.
  // Every output is computed one cycle ahead, so the registered value is
  // what the outside world sees while the FSM sits in the matching state.
  always_comb begin
    state_d      = state_q;
    sp_d         = sp_q;
    done_d       = 1'b0;
    ovf_d        = 1'b0;
    unf_d        = 1'b0;
    rf_wr_en_d   = 1'b0;
    mem_wr_d     = 1'b0;
    mem_rd_d     = 1'b0;
    pop_data_d   = pop_data_q;
    mem_addr_d   = mem_addr_q;
    mem_dout_d   = mem_dout_q;
    rf_wr_data_d = rf_wr_data_q;

    case (state_q)
      IDLE: begin
        if (push_req) begin
          sp_d = sp_in;
          if (is_full(sp_in)) begin
            // The push is refused: no memory or register-file activity.
            done_d = 1'b1;
            ovf_d  = 1'b1;
          end else begin
            state_d    = PUSH_MEM;
            mem_wr_d   = 1'b1;
            mem_addr_d = sp_in - 8'd1;
            mem_dout_d = push_data;
          end
        end else if (pop_req) begin
          sp_d = sp_in;
          if (is_empty(sp_in)) begin
            done_d = 1'b1;
            unf_d  = 1'b1;
          end else begin
            state_d    = POP_MEM;
            mem_rd_d   = 1'b1;
            mem_addr_d = sp_in;
          end
        end else begin
          state_d = IDLE;
        end
      end
      PUSH_MEM: begin
        state_d      = SP_WB;
        rf_wr_en_d   = 1'b1;
        done_d       = 1'b1;
        rf_wr_data_d = sp_q - 8'd1;
      end
      POP_MEM: begin
        // Memory read data is valid in the same cycle as mem_rd.
        state_d      = SP_WB;
        pop_data_d   = mem_din;
        rf_wr_en_d   = 1'b1;
        done_d       = 1'b1;
        rf_wr_data_d = sp_q + 8'd1;
      end
      SP_WB: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  // The asynchronous reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      sp_q         <= 8'h00;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      ovf_q        <= 1'b0;
      unf_q        <= 1'b0;
      rf_wr_en_q   <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_rd_q     <= 1'b0;
      pop_data_q   <= 8'h00;
      mem_addr_q   <= 8'h00;
      mem_dout_q   <= 8'h00;
      rf_wr_data_q <= 8'h00;
    end else begin
      state_q      <= state_d;
      sp_q         <= sp_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      ovf_q        <= ovf_d;
      unf_q        <= unf_d;
      rf_wr_en_q   <= rf_wr_en_d;
      mem_wr_q     <= mem_wr_d;
      mem_rd_q     <= mem_rd_d;
      pop_data_q   <= pop_data_d;
      mem_addr_q   <= mem_addr_d;
      mem_dout_q   <= mem_dout_d;
      rf_wr_data_q <= rf_wr_data_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign ovf        = ovf_q;
  assign unf        = unf_q;
  assign rf_wr_en   = rf_wr_en_q;
  assign rf_addr    = SP_ADDR;
  assign rf_wr_data = rf_wr_data_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wr     = mem_wr_q;
  assign mem_rd     = mem_rd_q;
  assign mem_dout   = mem_dout_q;
  assign pop_data   = pop_data_q;

endmodule
